// File: rtl/io_bus_parser_bank_if.sv
// CPU side of the memory-router io bus: address, read/write strobes and wait back-pressure.
// The tristate data lines stay a direct inout on the bank so they resolve with the router's drivers.
interface io_bus_parser_bank_if;
  logic [15:0] I_ADDR_BUS;
  logic        I_WE_BUS;
  logic        I_RE_BUS;
  logic        O_WAIT;

  modport master (output I_ADDR_BUS, output I_WE_BUS, output I_RE_BUS, input O_WAIT);
  modport slave  (input I_ADDR_BUS, input I_WE_BUS, input I_RE_BUS, output O_WAIT);
endinterface

// File: rtl/io_bus_parser_bank.sv
// Bank of contiguous 8-bit memory-mapped IO registers with CPU write masks, W1C bits,
// CPU write strobes and a one-deep deferred buffer for external writes that collide with CPU writes.
module io_bus_parser_bank #(
  parameter logic [15:0]             P_BASE_ADDR = 16'hFF04,
  parameter int unsigned             P_NUM_REGS  = 4,
  parameter logic [8*P_NUM_REGS-1:0] P_RST_VALS  = '0,
  parameter logic [8*P_NUM_REGS-1:0] P_WR_MASK   = '1,
  parameter logic [8*P_NUM_REGS-1:0] P_W1C_MASK  = '0
) (
  input  logic                      I_CLK,
  input  logic                      I_ASYNC_RESET,
  io_bus_parser_bank_if.slave       bus,
  inout  wire  [7:0]                IO_DATA_BUS,
  input  logic [8*P_NUM_REGS-1:0]   I_DATA_WR,
  input  logic [P_NUM_REGS-1:0]     I_REG_WR_EN,
  output logic [8*P_NUM_REGS-1:0]   O_DATA_READ,
  output logic [P_NUM_REGS-1:0]     O_CPU_WR_STB,
  output logic [P_NUM_REGS-1:0]     O_EXT_PEND
);

  logic [15:0]           offset;
  logic [3:0]            idx;
  logic                  hit;
  logic                  rd_req;
  logic                  rd_drv;
  logic [7:0]            rd_next;
  logic [7:0]            rd_data;
  logic [P_NUM_REGS-1:0] cpu_sel;
  logic [7:0]            regs      [P_NUM_REGS];
  logic [7:0]            pend_data [P_NUM_REGS];
  logic [7:0]            cpu_val   [P_NUM_REGS];

  // Unsigned wrap of the subtraction is harmless: the >= test rejects addresses below the base.
  assign offset = bus.I_ADDR_BUS - P_BASE_ADDR;
  assign hit    = (bus.I_ADDR_BUS >= P_BASE_ADDR) && (offset < 16'(P_NUM_REGS));
  assign idx    = offset[3:0];
  assign rd_req = hit & bus.I_RE_BUS & ~bus.I_WE_BUS;

  assign bus.O_WAIT  = hit & bus.I_WE_BUS;
  assign IO_DATA_BUS = rd_drv ? rd_data : 8'hzz;

  for (genvar g = 0; g < P_NUM_REGS; g++) begin : g_out
    assign O_DATA_READ[8*g +: 8] = regs[g];
  end

  // Read data forwards a same-cycle external write, then any deferred value, then the register.
  always_comb begin
    cpu_sel = '0;
    rd_next = '0;
    for (int i = 0; i < int'(P_NUM_REGS); i++) begin
      cpu_val[i] = (P_W1C_MASK[8*i +: 8] & regs[i] & ~IO_DATA_BUS)
                 | (~P_W1C_MASK[8*i +: 8] & P_WR_MASK[8*i +: 8] & IO_DATA_BUS)
                 | (~P_W1C_MASK[8*i +: 8] & ~P_WR_MASK[8*i +: 8] & regs[i]);
      if (hit && (idx == 4'(i))) begin
        cpu_sel[i] = bus.I_WE_BUS;
        if (I_REG_WR_EN[i]) begin
          rd_next = I_DATA_WR[8*i +: 8];
        end else if (O_EXT_PEND[i]) begin
          rd_next = pend_data[i];
        end else begin
          rd_next = regs[i];
        end
      end
    end
  end

  always_ff @(posedge I_CLK or posedge I_ASYNC_RESET) begin
    if (I_ASYNC_RESET) begin
      for (int i = 0; i < int'(P_NUM_REGS); i++) begin
        regs[i]      <= P_RST_VALS[8*i +: 8];
        pend_data[i] <= '0;
      end
      O_CPU_WR_STB <= '0;
      O_EXT_PEND   <= '0;
      rd_drv       <= 1'b0;
      rd_data      <= '0;
    end else begin
      O_CPU_WR_STB <= cpu_sel;
      rd_drv       <= rd_req;
      rd_data      <= rd_next;
      for (int i = 0; i < int'(P_NUM_REGS); i++) begin
        if (cpu_sel[i]) begin
          regs[i] <= cpu_val[i];
          // A colliding external write is parked rather than lost; a newer collision replaces it.
          if (I_REG_WR_EN[i]) begin
            pend_data[i]  <= I_DATA_WR[8*i +: 8];
            O_EXT_PEND[i] <= 1'b1;
          end
        end else if (I_REG_WR_EN[i]) begin
          regs[i]       <= I_DATA_WR[8*i +: 8];
          O_EXT_PEND[i] <= 1'b0;
        end else if (O_EXT_PEND[i]) begin
          regs[i]       <= pend_data[i];
          O_EXT_PEND[i] <= 1'b0;
        end
      end
    end
  end

endmodule
